// File: rtl/chs_pkg.sv
// chs_pkg: shared types, field positions and mapping helpers for chs_controller.
package chs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      COOL = 2'b01,
      HEAT = 2'b10,
      HOLD = 2'b11
   } chs_state_e;

   localparam int MODE_BIT  = 7;
   localparam int POWER_LSB = 0;
   localparam int POWER_W   = 4;

   localparam logic [7:0]         SPEED_MAX   = 8'hFF;
   localparam logic [POWER_W-1:0] POWER_MAX   = 4'hF;
   localparam int                 SPEED_SCALE = 16;

   // min(diff, POWER_MAX)
   function automatic logic [POWER_W-1:0] power_of(input logic [7:0] diff);
      return (diff > 8'(POWER_MAX)) ? POWER_MAX : diff[POWER_W-1:0];
   endfunction

   // min(diff * SPEED_SCALE, SPEED_MAX), saturating before the product overflows
   function automatic logic [7:0] speed_of(input logic [7:0] diff);
      return (diff > 8'(SPEED_MAX / 8'(SPEED_SCALE))) ? SPEED_MAX : 8'(diff * 8'(SPEED_SCALE));
   endfunction

endpackage

// File: rtl/chs_if.sv
// chs_if: sample/enable inputs and regulation outputs of chs_controller.
//   master: drives enable, sample_valid, cur_temp, target_temp; observes outputs.
//   slave : the controller side.
interface chs_if;
   logic       enable;
   logic       sample_valid;
   logic [7:0] cur_temp;
   logic [7:0] target_temp;
   logic [7:0] chs_conf;
   logic       chs_mode;
   logic [3:0] chs_power;
   logic [7:0] speed;
   logic [1:0] state;

   modport master (
      output enable, sample_valid, cur_temp, target_temp,
      input  chs_conf, chs_mode, chs_power, speed, state
   );

   modport slave (
      input  enable, sample_valid, cur_temp, target_temp,
      output chs_conf, chs_mode, chs_power, speed, state
   );
endinterface

// File: rtl/chs_speed_ramp.sv
// chs_speed_ramp: slews speed toward target by 1 LSB every RAMP_DIV clocks.
//   clk    : system clock, rising edge
//   arst   : asynchronous active-low reset
//   target : speed target (next-cycle value from the controller)
//   speed  : ramped fan duty byte
module chs_speed_ramp #(
   parameter int RAMP_DIV = 16
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] target,
   output logic [7:0] speed
);

   localparam int CW = $clog2(RAMP_DIV + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    tgt_q, spd_q, spd_d;
   logic          step;

   // tgt_q remembers the last target so a change restarts the divider
   always_comb begin
      step  = (target == tgt_q) && (spd_q != target) && (cnt_q == CW'(RAMP_DIV - 1));
      cnt_d = (target != tgt_q || spd_q == target || step) ? '0 : cnt_q + CW'(1);
      spd_d = !step ? spd_q : (spd_q < target) ? spd_q + 8'd1 : spd_q - 8'd1;
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt_q <= '0;
         tgt_q <= '0;
         spd_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= target;
         spd_q <= spd_d;
      end
   end

   assign speed = spd_q;

endmodule

// File: rtl/chs_controller.sv
// chs_controller: hysteresis/dwell cool-heat sequencer driving chs_conf and fan speed.
//   clk  : system clock, rising edge
//   arst : asynchronous active-low reset
//   bus  : chs_if.slave (enable, sample_valid, cur_temp, target_temp in;
//          chs_conf, chs_mode, chs_power, speed, state out)
//   Build option CHS_RAMP_EN: slew speed through chs_speed_ramp instead of a plain register.
module chs_controller
   import chs_pkg::*;
#(
   parameter int HYST         = 2,
   parameter int DWELL_CYCLES = 1000,
   parameter int RAMP_DIV     = 16
) (
   input logic  clk,
   input logic  arst,
   chs_if.slave bus
);

   localparam int DW = $clog2(DWELL_CYCLES + 1);

   if (HYST > 15 || DWELL_CYCLES < 1 || RAMP_DIV < 1) begin : g_param_check
      $error("chs_controller: parameter out of range");
   end

   chs_state_e   state_q, state_d;
   logic [7:0]   cur_q, cur_d, tgt_q, tgt_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic         mode_q, mode_d;
   logic [3:0]   power_q, power_d;
   logic [7:0]   spd_tgt_d, speed, diff, conf;
   logic [8:0]   c9, t9;
   logic         active;

   // 9-bit compares so tgt+HYST and cur+HYST cannot wrap
   assign c9 = {1'b0, cur_q};
   assign t9 = {1'b0, tgt_q};

   always_comb begin
      cur_d   = bus.sample_valid ? bus.cur_temp : cur_q;
      tgt_d   = bus.sample_valid ? bus.target_temp : tgt_q;
      diff    = (cur_q >= tgt_q) ? cur_q - tgt_q : tgt_q - cur_q;
      state_d = state_q;
      case (state_q)
         IDLE: state_d = !bus.enable ? IDLE :
                         (c9 > t9 + 9'(HYST)) ? COOL :
                         (c9 + 9'(HYST) < t9) ? HEAT : IDLE;
         COOL: if (!bus.enable || cur_q <= tgt_q) state_d = HOLD;
         HEAT: if (!bus.enable || cur_q >= tgt_q) state_d = HOLD;
         HOLD: if (dwell_q == '0) state_d = IDLE;
      endcase
      dwell_d   = (state_d == HOLD && state_q != HOLD) ? DW'(DWELL_CYCLES - 1) :
                  (state_q == HOLD && dwell_q != '0) ? dwell_q - DW'(1) : dwell_q;
      active    = (state_d == COOL) || (state_d == HEAT);
      power_d   = active ? power_of(diff) : '0;
      // mode sticks through HOLD so the decoder keeps its last direction
      mode_d    = (state_d == HEAT) || (state_d == HOLD && mode_q);
      spd_tgt_d = active ? speed_of(diff) : '0;
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         dwell_q <= '0;
         mode_q  <= 1'b0;
         power_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         dwell_q <= dwell_d;
         mode_q  <= mode_d;
         power_q <= power_d;
      end
   end

`ifdef CHS_RAMP_EN
   // ramp sees the next-cycle target so its divider starts on the same edge the target moves
   chs_speed_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
      .clk    (clk),
      .arst   (arst),
      .target (spd_tgt_d),
      .speed  (speed)
   );
`else
   logic [7:0] speed_q;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) speed_q <= '0;
      else       speed_q <= spd_tgt_d;
   end

   assign speed = speed_q;
`endif

   always_comb begin
      conf                         = '0;
      conf[MODE_BIT]               = mode_q;
      conf[POWER_LSB +: POWER_W]   = power_q;
   end

   assign bus.chs_conf  = conf;
   assign bus.chs_mode  = mode_q;
   assign bus.chs_power = power_q;
   assign bus.speed     = speed;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_chs_controller.sv
// tb_chs_controller: randomized scoreboard bench for chs_controller against a rule-level model.
module tb_chs_controller;

   localparam int HYST  = 2;
   localparam int DWELL = 8;
   localparam int RD    = 4;

   logic clk  = 1'b0;
   logic arst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   chs_if bus ();

   chs_controller #(
      .HYST         (HYST),
      .DWELL_CYCLES (DWELL),
      .RAMP_DIV     (RD)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int conf;
      int mode;
      int pwr;
      int spd;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".state"}, 32'(bus.state), 0);
      chk({tag, ".conf"},  32'(bus.chs_conf), 0);
      chk({tag, ".mode"},  32'(bus.chs_mode), 0);
      chk({tag, ".power"}, 32'(bus.chs_power), 0);
      chk({tag, ".speed"}, 32'(bus.speed), 0);
   endtask

   // Reference model: state numbers follow the output encoding (0 idle, 1 cool, 2 heat, 3 hold);
   // dwell is tracked as elapsed cycles since HOLD entry, ramp as elapsed cycles since target change.
   int   m_st, m_cur, m_tgt, m_mode, m_pwr, m_spd, m_hold, cyc;
   int   c, t, d, ns, spt;
   logic en, act;
   exp_t ne;
`ifdef CHS_RAMP_EN
   int   m_spt, m_chg;
`endif

   initial forever begin
      @(posedge clk or negedge arst);
      if (!arst) begin
         m_st = 0; m_cur = 0; m_tgt = 0; m_mode = 0; m_pwr = 0; m_spd = 0;
`ifdef CHS_RAMP_EN
         m_spt = 0;
`endif
         q.delete();
      end else begin
         c  = m_cur;
         t  = m_tgt;
         en = bus.enable;
         d  = (c > t) ? c - t : t - c;
         ns = m_st;
         if (m_st == 0)      ns = !en ? 0 : (c > t + HYST) ? 1 : (c + HYST < t) ? 2 : 0;
         else if (m_st == 1) ns = (!en || c <= t) ? 3 : 1;
         else if (m_st == 2) ns = (!en || c >= t) ? 3 : 2;
         else if (cyc - m_hold == DWELL) ns = 0;
         if (ns == 3 && m_st != 3) m_hold = cyc;
         act    = (ns == 1) || (ns == 2);
         m_pwr  = act ? ((d < 15) ? d : 15) : 0;
         m_mode = (ns == 2) ? 1 : (ns == 3) ? m_mode : 0;
         spt    = act ? ((d * 16 < 255) ? d * 16 : 255) : 0;
`ifdef CHS_RAMP_EN
         if (spt != m_spt) m_chg = cyc;
         m_spt = spt;
         if (cyc - m_chg > 0 && (cyc - m_chg) % RD == 0 && m_spd != spt)
            m_spd += (m_spd < spt) ? 1 : -1;
`else
         m_spd = spt;
`endif
         if (bus.sample_valid) begin
            m_cur = int'(bus.cur_temp);
            m_tgt = int'(bus.target_temp);
         end
         m_st = ns;
         cyc++;
         ne.st   = m_st;
         ne.conf = m_mode * 128 + m_pwr;
         ne.mode = m_mode;
         ne.pwr  = m_pwr;
         ne.spd  = m_spd;
         q.push_back(ne);
      end
   end

   exp_t e;

   initial forever begin
      @(posedge clk);
      #1;
      if (arst) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("state", 32'(bus.state), e.st);
            chk("conf",  32'(bus.chs_conf), e.conf);
            chk("mode",  32'(bus.chs_mode), e.mode);
            chk("power", 32'(bus.chs_power), e.pwr);
            chk("speed", 32'(bus.speed), e.spd);
         end
      end
   end

   task automatic drv(input logic en_i, input logic sv, input int cv, input int tv);
      @(negedge clk);
      bus.enable       = en_i;
      bus.sample_valid = sv;
      bus.cur_temp     = 8'(cv);
      bus.target_temp  = 8'(tv);
   endtask

   task automatic run(input int n);
      repeat (n) drv(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
   endtask

   task automatic rand_in();
      bus.enable       = 1'($urandom);
      bus.sample_valid = 1'($urandom);
      bus.cur_temp     = 8'($urandom);
      bus.target_temp  = 8'($urandom);
   endtask

   // reset lands mid-cycle so the outputs must clear without a clock edge
   task automatic do_reset(input int n);
      @(negedge clk);
      #2;
      arst = 1'b0;
      rand_in();
      #1;
      chk_zero("reset_async");
      repeat (n) begin
         @(negedge clk);
         rand_in();
         #1;
         chk_zero("reset_hold");
      end
      @(negedge clk);
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      #2;
      arst = 1'b1;
   endtask

   initial begin
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      bus.cur_temp     = '0;
      bus.target_temp  = '0;
      do_reset(3);
      run(3);
      drv(1, 1, 30, 20);          // cool entry
      run(6);
      drv(1, 1, 20, 20);          // cool exit into hold
      run(12);
      drv(1, 1, 21, 20);          // inside hysteresis band
      run(3);
      drv(1, 1, 18, 20);
      run(3);
      drv(1, 1, 10, 40);          // heat, saturated power
      run(4);
      drv(1, 1, 40, 40);          // heat exit into hold
      run(2);
      drv(1, 1, 50, 20);          // dwell lockout, then cool
      run(12);
      drv(0, 1, 60, 20);          // enable drop wins over sample
      run(12);
      drv(1, 1, 250, 254);        // near top of range, no wrap
      run(12);
      drv(1, 1, 255, 0);
      run(4);
      drv(1, 1, 0, 0);
      run(12);
      drv(1, 1, 30, 20);
      run(150);
      do_reset(1);                // abort mid-ramp
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(0, 2)));
         else drv($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(10, 40)),
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(15, 35)));
      end
      drv(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
